video_sync_gen: RTL and testbench
=================================

VIDEO_SYNC_GEN -- requirements
Module: video_sync_gen

Interface
REQ-001 Parameters SHALL be:
- pHdisplay, 640, active pixels per line
- pHfront, 16, horizontal front porch in pixels
- pHsync, 96, hsync pulse width in pixels
- pHback, 48, horizontal back porch in pixels
- pVdisplay, 480, active lines per frame
- pVbottom, 11, vertical front porch in lines
- pVsync, 2, vsync pulse width in lines
- pVtop, 31, vertical back porch in lines
- pSyncPol, 0, sync active level (0 = active-low)
- pFetchLead, 2, cycles oFvde leads oVde
REQ-002 Ports SHALL be:
- iPixelClk, in, 1, pixel clock; the only clock
- iRst, in, 1, synchronous active-high reset
- oHpos, out, 12, current horizontal position
- oVpos, out, 12, current vertical position
- oVde, out, 1, active video
- oFvde, out, 1, pixel-fetch enable ahead of oVde
- oHsync, out, 1, horizontal sync
- oVsync, out, 1, vertical sync
- oFe, out, 1, frame-end pulse

Function
REQ-003 HT = pHdisplay+pHfront+pHsync+pHback and VT = pVdisplay+pVbottom+pVsync+pVtop SHALL be derived constants (800 and 524 at defaults).
REQ-004 Horizontal position h SHALL step 0..HT-1 once per iPixelClk and wrap to 0.
REQ-005 Vertical position v SHALL advance only in the cycle h wraps, stepping 0..VT-1 and wrapping to 0.
REQ-006 All outputs SHALL be registered, with no combinational path from any input.
REQ-007 All outputs SHALL describe the same position (h,v) in the same cycle; oHpos=h and oVpos=v.
REQ-008 oVde SHALL be 1 iff h<pHdisplay and v<pVdisplay.
REQ-009 oHsync SHALL be at the active level iff pHdisplay+pHfront <= h < pHdisplay+pHfront+pHsync.
REQ-010 oVsync SHALL be at the active level for all h of lines pVdisplay+pVbottom <= v < pVdisplay+pVbottom+pVsync.
REQ-011 Each sync output SHALL be at its inactive level otherwise.
REQ-012 oFvde SHALL be 1 iff the position reached pFetchLead cycles later satisfies REQ-008, including wrap from (HT-1,VT-1) into (0,0).
REQ-013 oFvde therefore SHALL assert at h=HT-pFetchLead of line VT-1 for frame line 0.
REQ-014 pFetchLead SHALL satisfy 1 <= pFetchLead <= pHfront+pHsync+pHback; out-of-range values SHALL be a compile-time error.
REQ-015 oFe SHALL pulse for exactly one cycle at (pHdisplay, pVdisplay-1), the first cycle after the frame's last oVde.
REQ-016 The outputs SHALL have no handshake or stall: timing is free-running.

Reset
REQ-017 While iRst=1, the outputs SHALL hold oHpos=0, oVpos=0, oVde=0, oFvde=0, oFe=0, and oHsync/oVsync at the inactive level.
REQ-018 The first cycle after iRst deasserts SHALL present (0,0) with oVde=1.
REQ-019 In the first line after reset, oFvde SHALL be truncated: 1 at h=0..pHdisplay-pFetchLead-1 only.
REQ-020 Reset asserted mid-frame SHALL abandon the frame without producing oFe, then restart per REQ-018.

Structure
REQ-021 HT, VT, sync start/end positions and counter widths ($clog2) SHALL live in a shared video-timing package, reused by the frame buffer and the TMDS encoder stage.
REQ-022 Each axis SHALL use one sub-module, sync_axis_counter (wrap counter with count-enable), instantiated once for h and once for v.

Verification
REQ-023 At defaults, release reset and run 2 frames: oVde high 307200 cycles per frame; frame period 419200 cycles; oFe period 419200 cycles.
REQ-024 At defaults, check a line: oHsync low for h=656..751 (96 cycles); oVsync low for v=491..492, 1600 cycles.
REQ-025 With pFetchLead=4: oFvde rises 4 cycles before every oVde rise (except the first line after reset) and falls 4 cycles before oVde falls; the line-0 window starts at (796,523).
REQ-026 Assert iRst at (300,200) for 3 cycles: outputs hold reset values; the next cycle shows (0,0) with oVde=1; no oFe until (640,479).
REQ-027 With pSyncPol=1 and a reduced timing (8/2/2/2 x 4/1/1/1): syncs are high-active and HT=14, VT=7; check all flags exhaustively against a reference model over 3 frames.

Source files
------------

// File: rtl/video_sync_gen_pkg.sv
// rtl/video_sync_gen_pkg.sv - shared video-timing constants, helpers and run-state type
package video_sync_gen_pkg;

   localparam int unsigned POS_W = 12;

   localparam int unsigned DEF_HDISPLAY = 640;
   localparam int unsigned DEF_HFRONT   = 16;
   localparam int unsigned DEF_HSYNC    = 96;
   localparam int unsigned DEF_HBACK    = 48;
   localparam int unsigned DEF_VDISPLAY = 480;
   localparam int unsigned DEF_VBOTTOM  = 11;
   localparam int unsigned DEF_VSYNC    = 2;
   localparam int unsigned DEF_VTOP     = 31;

   function automatic int unsigned axis_total(input int unsigned disp, input int unsigned front,
                                              input int unsigned sync, input int unsigned back);
      return disp + front + sync + back;
   endfunction

   function automatic int unsigned sync_start(input int unsigned disp, input int unsigned front);
      return disp + front;
   endfunction

   function automatic int unsigned sync_end(input int unsigned disp, input int unsigned front,
                                            input int unsigned sync);
      return disp + front + sync;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned total);
      return (total > 1) ? $clog2(total) : 1;
   endfunction

   typedef enum logic {
      ST_IDLE,
      ST_RUN
   } run_state_e;

endpackage

// File: rtl/video_sync_gen_if.sv
// rtl/video_sync_gen_if.sv - bundled timing outputs for downstream fetch/encode stages
interface video_sync_gen_if;
   import video_sync_gen_pkg::*;

   logic [POS_W-1:0] hpos;
   logic [POS_W-1:0] vpos;
   logic             vde;
   logic             fvde;
   logic             hsync;
   logic             vsync;
   logic             fe;

   modport master (output hpos, vpos, vde, fvde, hsync, vsync, fe);
   modport slave  (input  hpos, vpos, vde, fvde, hsync, vsync, fe);

endinterface

// File: rtl/sync_axis_counter.sv
// rtl/sync_axis_counter.sv - wrap counter with count-enable, exposes its next value
module sync_axis_counter #(
   parameter int unsigned pWidth = 10,
   parameter int unsigned pTotal = 800
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clr_i,
   input  logic              en_i,
   output logic [pWidth-1:0] cnt_o,
   output logic [pWidth-1:0] cnt_d_o
);

   localparam logic [pWidth-1:0] LAST = pWidth'(pTotal - 1);

   logic [pWidth-1:0] cnt_q;
   logic [pWidth-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o   = cnt_q;
   assign cnt_d_o = cnt_d;

endmodule

// File: rtl/video_sync_gen.sv
// rtl/video_sync_gen.sv - free-running raster timing: position, active video, fetch-ahead, syncs, frame end
module video_sync_gen
   import video_sync_gen_pkg::*;
#(
   parameter int unsigned pHdisplay  = DEF_HDISPLAY,
   parameter int unsigned pHfront    = DEF_HFRONT,
   parameter int unsigned pHsync     = DEF_HSYNC,
   parameter int unsigned pHback     = DEF_HBACK,
   parameter int unsigned pVdisplay  = DEF_VDISPLAY,
   parameter int unsigned pVbottom   = DEF_VBOTTOM,
   parameter int unsigned pVsync     = DEF_VSYNC,
   parameter int unsigned pVtop      = DEF_VTOP,
   parameter int unsigned pSyncPol   = 0,
   parameter int unsigned pFetchLead = 2
) (
   input  logic             iPixelClk,
   input  logic             iRst,
   output logic [POS_W-1:0] oHpos,
   output logic [POS_W-1:0] oVpos,
   output logic             oVde,
   output logic             oFvde,
   output logic             oHsync,
   output logic             oVsync,
   output logic             oFe,
   video_sync_gen_if.master vid_o
);

   localparam int unsigned HT       = axis_total(pHdisplay, pHfront, pHsync, pHback);
   localparam int unsigned VT       = axis_total(pVdisplay, pVbottom, pVsync, pVtop);
   localparam int unsigned HS_START = sync_start(pHdisplay, pHfront);
   localparam int unsigned HS_END   = sync_end(pHdisplay, pHfront, pHsync);
   localparam int unsigned VS_START = sync_start(pVdisplay, pVbottom);
   localparam int unsigned VS_END   = sync_end(pVdisplay, pVbottom, pVsync);
   localparam int unsigned H_W      = cnt_width(HT);
   localparam int unsigned V_W      = cnt_width(VT);
   localparam logic        ACT      = (pSyncPol != 0);
   localparam logic        INACT    = !ACT;

   if (pFetchLead < 1 || pFetchLead > pHfront + pHsync + pHback) begin : g_bad_lead
      $error("pFetchLead must lie in 1..pHfront+pHsync+pHback");
   end
   if (H_W > POS_W || V_W > POS_W) begin : g_bad_width
      $error("timing totals exceed position port width");
   end

   run_state_e       state_q, state_d;
   logic             h_clr, h_en, h_last, v_en;
   logic [H_W-1:0]   h_q, h_d;
   logic [V_W-1:0]   v_q, v_d;
   logic [31:0]      hn, vn, hf, vf;
   logic             vde_d, fvde_d, hsync_d, vsync_d, fe_d;
   logic             vde_q, fvde_q, hsync_q, vsync_q, fe_q;

   // IDLE lasts one cycle after reset so the first running cycle presents (0,0).
   always_ff @(posedge iPixelClk) begin
      if (iRst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      h_clr   = 1'b0;
      h_en    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            state_d = ST_RUN;
            h_clr   = 1'b1;
         end
         ST_RUN:  h_en = 1'b1;
         default: state_d = ST_IDLE;
      endcase
   end

   assign h_last = (h_q == H_W'(HT - 1));
   assign v_en   = h_en && h_last;

   sync_axis_counter #(.pWidth(H_W), .pTotal(HT)) u_h_cnt (
      .clk_i   (iPixelClk),
      .rst_i   (iRst),
      .clr_i   (h_clr),
      .en_i    (h_en),
      .cnt_o   (h_q),
      .cnt_d_o (h_d)
   );

   sync_axis_counter #(.pWidth(V_W), .pTotal(VT)) u_v_cnt (
      .clk_i   (iPixelClk),
      .rst_i   (iRst),
      .clr_i   (h_clr),
      .en_i    (v_en),
      .cnt_o   (v_q),
      .cnt_d_o (v_d)
   );

   // Flags decode the counters' next position so they register alongside it.
   // The fetch lead never exceeds the horizontal blanking, so one line wrap suffices.
   always_comb begin
      hn = 32'(h_d);
      vn = 32'(v_d);
      hf = hn + pFetchLead;
      vf = vn;
      if (hf >= HT) begin
         hf = hf - HT;
         vf = (vn == VT - 1) ? 32'd0 : vn + 32'd1;
      end
      vde_d   = (hn < pHdisplay) && (vn < pVdisplay);
      fvde_d  = (hf < pHdisplay) && (vf < pVdisplay);
      hsync_d = (hn >= HS_START && hn < HS_END) ? ACT : INACT;
      vsync_d = (vn >= VS_START && vn < VS_END) ? ACT : INACT;
      fe_d    = (hn == pHdisplay) && (vn == pVdisplay - 1);
   end

   always_ff @(posedge iPixelClk) begin
      if (iRst) begin
         vde_q   <= 1'b0;
         fvde_q  <= 1'b0;
         hsync_q <= INACT;
         vsync_q <= INACT;
         fe_q    <= 1'b0;
      end else begin
         vde_q   <= vde_d;
         fvde_q  <= fvde_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
         fe_q    <= fe_d;
      end
   end

   assign oHpos  = POS_W'(h_q);
   assign oVpos  = POS_W'(v_q);
   assign oVde   = vde_q;
   assign oFvde  = fvde_q;
   assign oHsync = hsync_q;
   assign oVsync = vsync_q;
   assign oFe    = fe_q;

   assign vid_o.hpos  = oHpos;
   assign vid_o.vpos  = oVpos;
   assign vid_o.vde   = oVde;
   assign vid_o.fvde  = oFvde;
   assign vid_o.hsync = oHsync;
   assign vid_o.vsync = oVsync;
   assign vid_o.fe    = oFe;

endmodule

// File: tb/tb_video_sync_gen.sv
// tb/tb_video_sync_gen.sv - directed bench for video_sync_gen across four parameter sets
module tb_video_sync_gen;
   import video_sync_gen_pkg::*;

   typedef struct packed {
      logic [11:0] h;
      logic [11:0] v;
      logic        vde;
      logic        fvde;
      logic        hs;
      logic        vs;
      logic        fe;
   } obs_t;

   logic clk;
   logic rst_f, rst_m, rst_l, rst_s;
   int   tests, fails;

   logic [11:0] f_h, f_v, m_h, m_v, l_h, l_v, s_h, s_v;
   logic f_vde, f_fvde, f_hs, f_vs, f_fe;
   logic m_vde, m_fvde, m_hs, m_vs, m_fe;
   logic l_vde, l_fvde, l_hs, l_vs, l_fe;
   logic s_vde, s_fvde, s_hs, s_vs, s_fe;

   video_sync_gen_if if_f ();
   video_sync_gen_if if_m ();
   video_sync_gen_if if_l ();
   video_sync_gen_if if_s ();

   video_sync_gen dut_f (
      .iPixelClk(clk), .iRst(rst_f), .oHpos(f_h), .oVpos(f_v), .oVde(f_vde), .oFvde(f_fvde),
      .oHsync(f_hs), .oVsync(f_vs), .oFe(f_fe), .vid_o(if_f)
   );

   video_sync_gen #(.pVdisplay(12), .pVbottom(2), .pVsync(2), .pVtop(3)) dut_m (
      .iPixelClk(clk), .iRst(rst_m), .oHpos(m_h), .oVpos(m_v), .oVde(m_vde), .oFvde(m_fvde),
      .oHsync(m_hs), .oVsync(m_vs), .oFe(m_fe), .vid_o(if_m)
   );

   video_sync_gen #(.pVdisplay(12), .pVbottom(2), .pVsync(2), .pVtop(3), .pFetchLead(4)) dut_l (
      .iPixelClk(clk), .iRst(rst_l), .oHpos(l_h), .oVpos(l_v), .oVde(l_vde), .oFvde(l_fvde),
      .oHsync(l_hs), .oVsync(l_vs), .oFe(l_fe), .vid_o(if_l)
   );

   video_sync_gen #(.pHdisplay(8), .pHfront(2), .pHsync(2), .pHback(2), .pVdisplay(4),
                    .pVbottom(1), .pVsync(1), .pVtop(1), .pSyncPol(1)) dut_s (
      .iPixelClk(clk), .iRst(rst_s), .oHpos(s_h), .oVpos(s_v), .oVde(s_vde), .oFvde(s_fvde),
      .oHsync(s_hs), .oVsync(s_vs), .oFe(s_fe), .vid_o(if_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // n counts cycles since the first running cycle (which shows position 0,0).
   function automatic obs_t model(input int n, input int hd, input int hfp, input int hsw,
                                  input int hbp, input int vd, input int vbp, input int vsw,
                                  input int vtp, input int lead, input int pol);
      int ht, vt, h, v, hl, vl;
      obs_t e;
      ht     = hd + hfp + hsw + hbp;
      vt     = vd + vbp + vsw + vtp;
      h      = n % ht;
      v      = (n / ht) % vt;
      hl     = (n + lead) % ht;
      vl     = ((n + lead) / ht) % vt;
      e.h    = 12'(h);
      e.v    = 12'(v);
      e.vde  = (h < hd) && (v < vd);
      e.fvde = (hl < hd) && (vl < vd);
      e.hs   = (h >= hd + hfp && h < hd + hfp + hsw) ? pol[0] : ~pol[0];
      e.vs   = (v >= vd + vbp && v < vd + vbp + vsw) ? pol[0] : ~pol[0];
      e.fe   = (h == hd) && (v == vd - 1);
      return e;
   endfunction

   function automatic obs_t exp_f(input int n); return model(n, 640, 16, 96, 48, 480, 11, 2, 31, 2, 0); endfunction
   function automatic obs_t exp_m(input int n); return model(n, 640, 16, 96, 48, 12, 2, 2, 3, 2, 0); endfunction
   function automatic obs_t exp_l(input int n); return model(n, 640, 16, 96, 48, 12, 2, 2, 3, 4, 0); endfunction
   function automatic obs_t exp_s(input int n); return model(n, 8, 2, 2, 2, 4, 1, 1, 1, 2, 1); endfunction

   function automatic obs_t rst_val(input int pol);
      obs_t e;
      e = '0;
      e.hs = ~pol[0];
      e.vs = ~pol[0];
      return e;
   endfunction

   function automatic obs_t obs_f(); obs_t o; o = {f_h, f_v, f_vde, f_fvde, f_hs, f_vs, f_fe}; return o; endfunction
   function automatic obs_t obs_m(); obs_t o; o = {m_h, m_v, m_vde, m_fvde, m_hs, m_vs, m_fe}; return o; endfunction
   function automatic obs_t obs_l(); obs_t o; o = {l_h, l_v, l_vde, l_fvde, l_hs, l_vs, l_fe}; return o; endfunction
   function automatic obs_t obs_s(); obs_t o; o = {s_h, s_v, s_vde, s_fvde, s_hs, s_vs, s_fe}; return o; endfunction

   task automatic test_reset();
      obs_t got, e, ifv;
      repeat (3) @(negedge clk);
      e = rst_val(0);
      got = obs_f(); tests++;
      if (got !== e) begin fails++; $display("FAIL reset_f got %h exp %h", got, e); end
      got = obs_m(); tests++;
      if (got !== e) begin fails++; $display("FAIL reset_m got %h exp %h", got, e); end
      got = obs_l(); tests++;
      if (got !== e) begin fails++; $display("FAIL reset_l got %h exp %h", got, e); end
      ifv = {if_f.hpos, if_f.vpos, if_f.vde, if_f.fvde, if_f.hsync, if_f.vsync, if_f.fe}; tests++;
      if (ifv !== e) begin fails++; $display("FAIL reset_if_f got %h exp %h", ifv, e); end
      e = rst_val(1);
      got = obs_s(); tests++;
      if (got !== e) begin fails++; $display("FAIL reset_s got %h exp %h", got, e); end
      ifv = {if_s.hpos, if_s.vpos, if_s.vde, if_s.fvde, if_s.hsync, if_s.vsync, if_s.fe}; tests++;
      if (ifv !== e) begin fails++; $display("FAIL reset_if_s got %h exp %h", ifv, e); end
   endtask

   task automatic test_default_lines();
      obs_t got, e;
      int hs_cnt = 0, hs_first = -1, hs_last = -1, fv_early = -1, fv_late = -1;
      rst_f = 1'b0;
      for (int n = 0; n < 1700; n++) begin
         @(negedge clk);
         got = obs_f(); e = exp_f(n); tests++;
         if (got !== e) begin fails++; $display("FAIL line_f n=%0d got %h exp %h", n, got, e); end
         if (n == 0) begin
            tests++;
            if (got.h !== 12'd0 || got.v !== 12'd0 || got.vde !== 1'b1) begin
               fails++; $display("FAIL first_cycle got h=%0d v=%0d vde=%b exp 0 0 1", got.h, got.v, got.vde);
            end
         end
         if (n < 800) begin
            if (got.hs === 1'b0) begin
               hs_cnt++;
               if (hs_first < 0) hs_first = n;
               hs_last = n;
            end
            if (got.fvde === 1'b1) begin
               if (n < 700) fv_early = n;
               else if (fv_late < 0) fv_late = n;
            end
         end
      end
      tests++; if (hs_cnt != 96) begin fails++; $display("FAIL hsync_width got %0d exp 96", hs_cnt); end
      tests++; if (hs_first != 656) begin fails++; $display("FAIL hsync_start got %0d exp 656", hs_first); end
      tests++; if (hs_last != 751) begin fails++; $display("FAIL hsync_end got %0d exp 751", hs_last); end
      tests++; if (fv_early != 637) begin fails++; $display("FAIL fvde_trunc_end got %0d exp 637", fv_early); end
      tests++; if (fv_late != 798) begin fails++; $display("FAIL fvde_line1_start got %0d exp 798", fv_late); end
   endtask

   task automatic test_frames();
      obs_t got, e;
      int vde_cnt[2] = '{0, 0};
      int fe_n[4] = '{-1, -1, -1, -1};
      int fe_seen = 0, vs_cnt = 0, vs_first = -1;
      rst_m = 1'b0;
      for (int n = 0; n < 30410; n++) begin
         @(negedge clk);
         got = obs_m(); e = exp_m(n); tests++;
         if (got !== e) begin fails++; $display("FAIL frame_m n=%0d got %h exp %h", n, got, e); end
         if (got.vde === 1'b1 && n < 30400) vde_cnt[n / 15200]++;
         if (got.fe === 1'b1) begin
            if (fe_seen < 4) fe_n[fe_seen] = n;
            fe_seen++;
         end
         if (n < 15200 && got.vs === 1'b0) begin
            vs_cnt++;
            if (vs_first < 0) vs_first = n;
         end
      end
      tests++; if (vde_cnt[0] != 7680) begin fails++; $display("FAIL vde_frame0 got %0d exp 7680", vde_cnt[0]); end
      tests++; if (vde_cnt[1] != 7680) begin fails++; $display("FAIL vde_frame1 got %0d exp 7680", vde_cnt[1]); end
      tests++; if (fe_seen != 2) begin fails++; $display("FAIL fe_count got %0d exp 2", fe_seen); end
      tests++; if (fe_n[0] != 9440) begin fails++; $display("FAIL fe_first got %0d exp 9440", fe_n[0]); end
      tests++; if (fe_n[1] - fe_n[0] != 15200) begin fails++; $display("FAIL fe_period got %0d exp 15200", fe_n[1] - fe_n[0]); end
      tests++; if (vs_cnt != 1600) begin fails++; $display("FAIL vsync_width got %0d exp 1600", vs_cnt); end
      tests++; if (vs_first != 11200) begin fails++; $display("FAIL vsync_start got %0d exp 11200", vs_first); end
   endtask

   task automatic test_reset_mid();
      obs_t got, e;
      int fe_cnt = 0;
      rst_m = 1'b1;
      @(negedge clk);
      rst_m = 1'b0;
      for (int n = 0; n <= 8300; n++) begin
         @(negedge clk);
         got = obs_m(); e = exp_m(n); tests++;
         if (got !== e) begin fails++; $display("FAIL pre_reset_m n=%0d got %h exp %h", n, got, e); end
      end
      rst_m = 1'b1;
      e = rst_val(0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         got = obs_m(); tests++;
         if (got !== e) begin fails++; $display("FAIL mid_reset_hold k=%0d got %h exp %h", k, got, e); end
      end
      rst_m = 1'b0;
      for (int n = 0; n <= 9440; n++) begin
         @(negedge clk);
         got = obs_m(); e = exp_m(n); tests++;
         if (got !== e) begin fails++; $display("FAIL post_reset_m n=%0d got %h exp %h", n, got, e); end
         if (got.fe === 1'b1) fe_cnt++;
      end
      tests++;
      if (fe_cnt != 1) begin fails++; $display("FAIL fe_after_reset got %0d exp 1", fe_cnt); end
   endtask

   task automatic test_fetch_lead();
      obs_t got, e;
      logic pv = 1'b0, pf = 1'b0;
      int fv_rise = -1, fv_fall = -1, win_start = -1;
      rst_l = 1'b0;
      for (int n = 0; n <= 16000; n++) begin
         @(negedge clk);
         got = obs_l(); e = exp_l(n); tests++;
         if (got !== e) begin fails++; $display("FAIL lead4 n=%0d got %h exp %h", n, got, e); end
         if (got.fvde === 1'b1 && !pf) begin
            fv_rise = n;
            if (n >= 15000 && n < 15200) win_start = n;
         end
         if (got.fvde === 1'b0 && pf) fv_fall = n;
         if (got.vde === 1'b1 && !pv && n > 0) begin
            tests++;
            if (fv_rise != n - 4) begin fails++; $display("FAIL lead4_rise vde_rise=%0d got fvde_rise=%0d exp %0d", n, fv_rise, n - 4); end
         end
         if (got.vde === 1'b0 && pv) begin
            tests++;
            if (fv_fall != n - 4) begin fails++; $display("FAIL lead4_fall vde_fall=%0d got fvde_fall=%0d exp %0d", n, fv_fall, n - 4); end
         end
         pv = got.vde;
         pf = got.fvde;
      end
      tests++;
      if (win_start != 15196) begin fails++; $display("FAIL lead4_line0_window got %0d exp 15196", win_start); end
   endtask

   task automatic test_small();
      obs_t got, e;
      int hs_cnt = 0, vs_cnt = 0, fe_cnt = 0, fe_first = -1;
      rst_s = 1'b0;
      for (int n = 0; n < 294; n++) begin
         @(negedge clk);
         got = obs_s(); e = exp_s(n); tests++;
         if (got !== e) begin fails++; $display("FAIL small n=%0d got %h exp %h", n, got, e); end
         if (got.hs === 1'b1) hs_cnt++;
         if (got.vs === 1'b1) vs_cnt++;
         if (got.fe === 1'b1) begin
            fe_cnt++;
            if (fe_first < 0) fe_first = n;
         end
      end
      tests++; if (hs_cnt != 42) begin fails++; $display("FAIL small_hsync_high got %0d exp 42", hs_cnt); end
      tests++; if (vs_cnt != 42) begin fails++; $display("FAIL small_vsync_high got %0d exp 42", vs_cnt); end
      tests++; if (fe_cnt != 3) begin fails++; $display("FAIL small_fe_count got %0d exp 3", fe_cnt); end
      tests++; if (fe_first != 50) begin fails++; $display("FAIL small_fe_first got %0d exp 50", fe_first); end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst_f = 1'b1;
      rst_m = 1'b1;
      rst_l = 1'b1;
      rst_s = 1'b1;
      test_reset();
      test_default_lines();
      test_frames();
      test_reset_mid();
      test_fetch_lead();
      test_small();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
